ecc_dec_ctrl: RTL and testbench
===============================

// Module: ecc_dec_ctrl
// PURPOSE
//  Sequencer for the ECC decode path. Captures one codeword per request, drives width selects to the
//  syndrome/number-of-errors unit, waits for its result, flips a single erroneous bit and returns the
//  corrected codeword with an error count. Sits between the AMBA register file and the syndrome unit.
// PARAMETERS
//  AMBA_WORD  32  codeword register width (Large codeword = 32 bits: 26 data + 6 parity)
//  SYN_LAT    1   cycles from codeword presentation to valid syndrome result (1..7)
// PORTS
//  clk            in   1          single clock, all state on rising edge
//  rst            in   1          asynchronous, active-high reset
//  start          in   1          decode request, sampled in IDLE only
//  cw_width       in   2          00=Small(8b) 01=Medium(16b) 10=Large(32b) 11=Large
//  codeword_in    in   AMBA_WORD  received codeword, sampled with start
//  syn_cw         out  AMBA_WORD  captured codeword presented to syndrome unit
//  syn_small      out  1          width select to syndrome unit
//  syn_medium     out  1          width select to syndrome unit
//  syn_nof        in   2          from syndrome unit: 00 none, 01 single, 10 double
//  syn_pos        in   5          from syndrome unit: 1-based error position, 0 = overall parity bit
//  busy           out  1          high from accepted start until done cycle inclusive
//  done           out  1          one-cycle pulse, results valid this cycle and held after
//  data_out       out  AMBA_WORD  corrected codeword, unused upper bits zero
//  num_of_errors  out  2          registered copy of syn_nof for this codeword
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, syn_small, syn_medium = 0; syn_cw, data_out, num_of_errors = 0.
//  - FSM IDLE -> WAIT -> FIX -> DONE -> IDLE.
//  - IDLE: start=1 latches codeword_in masked to active width (bits above 8/16 cleared) and cw_width;
//    next WAIT, busy=1. start=0 stays IDLE.
//  - WAIT: syn_cw/syn_small/syn_medium held stable; down-counter loaded with SYN_LAT, leaves when it hits
//    1 after SYN_LAT cycles, sampling syn_nof/syn_pos on the exit edge.
//  - FIX: nof=01, pos!=0 -> flip bit pos-1; nof=01, pos=0 -> flip MSB of active width (bit 7/15/31);
//    nof=01, pos-1 >= active width -> no flip, num_of_errors forced 10; nof=00 or 10 -> no flip.
//  - DONE: data_out and num_of_errors updated, done=1 for exactly one cycle, busy drops next cycle.
//  - Latency start -> done = SYN_LAT + 2 cycles; back-to-back request accepted the cycle after done.
//  - start while busy ignored (not queued). syn_nof=11 treated as 10 (uncorrectable).
//  - cw_width=11 behaves exactly as 10. syn_small = (width==00), syn_medium = (width==01), never both.
//  - rst mid-operation: immediate return to IDLE with reset values; the in-flight codeword is dropped.
//  - data_out/num_of_errors hold last result until next DONE.
// CONFIGURATION
//  ECC_ERR_CNT_EN defined: adds input cnt_clr (1) and outputs corr_cnt (16), uncorr_cnt (16); in DONE
//   corr_cnt++ if nof=01 corrected, uncorr_cnt++ if final nof=10; both saturate at 16'hFFFF;
//   cnt_clr zeroes both synchronously, clear wins over a same-cycle increment; reset value 0.
//  Not defined: ports and counters absent, all other behaviour identical.
// STRUCTURE
//  Package ecc_pkg: state enum {IDLE,WAIT,FIX,DONE}; width codes W_SMALL/W_MEDIUM/W_LARGE;
//   NOF codes NOF_NONE/NOF_SINGLE/NOF_DOUBLE; active-width masks per width code.
//  Sub-module ecc_bit_fix (combinational): codeword, width, nof, pos -> fixed codeword, out-of-range flag.
//  FSM, latency counter, result registers and optional counters stay in ecc_dec_ctrl.
// TESTING
//  - Large, codeword 32'h1234_5678, stub nof=00 -> done at SYN_LAT+2, data_out=32'h1234_5678, errors=00.
//  - Small, codeword 32'hFFFF_FF5A, nof=01 pos=3 -> syn_cw=32'h5A, syn_small=1, data_out=32'h5E, errors=01.
//  - Medium, 16'h8001, nof=01 pos=0 -> data_out=32'h0001; nof=01 pos=20 -> no flip, errors=10.
//  - Large, nof=10 pos=9 -> data_out unchanged, errors=10; start pulsed while busy -> ignored, one done.
//  - rst asserted in WAIT -> busy=0, done never pulses, new start accepted first cycle after release.
//  - ECC_ERR_CNT_EN: 3 single + 2 double decodes -> corr_cnt=3, uncorr_cnt=2; cnt_clr with DONE -> 0.

Source files
------------

// File: rtl/ecc_dec_ctrl_pkg.sv
// ecc_pkg: shared types and constants for the ECC decode sequencer.
//   state_t      : sequencer states IDLE/WAIT/FIX/DONE
//   W_*          : codeword width codes (2'b11 decodes as Large)
//   NOF_*        : number-of-errors codes from the syndrome unit
//   width_mask() : active-bit mask for a width code
//   act_bits()   : number of active bits for a width code
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] W_SMALL  = 2'b00;
    localparam logic [1:0] W_MEDIUM = 2'b01;
    localparam logic [1:0] W_LARGE  = 2'b10;

    localparam logic [1:0] NOF_NONE   = 2'b00;
    localparam logic [1:0] NOF_SINGLE = 2'b01;
    localparam logic [1:0] NOF_DOUBLE = 2'b10;

    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            W_SMALL:  width_mask = 32'h0000_00FF;
            W_MEDIUM: width_mask = 32'h0000_FFFF;
            default:  width_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [5:0] act_bits(input logic [1:0] width);
        case (width)
            W_SMALL:  act_bits = 6'd8;
            W_MEDIUM: act_bits = 6'd16;
            default:  act_bits = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/ecc_dec_ctrl_if.sv
// ecc_dec_ctrl_if: request/response and syndrome-unit signals of the decode sequencer.
//   Request side : start, cw_width, codeword_in -> busy, done, data_out, num_of_errors
//   Syndrome side: syn_cw, syn_small, syn_medium -> syn_nof, syn_pos
//   dbg_state    : current sequencer state, for observation only
// Handshake: start is a request that is taken only while the sequencer is idle (busy low);
// a start seen while busy is dropped, not queued. busy rises the cycle after acceptance and
// stays high up to and including the single-cycle done pulse; data_out/num_of_errors are valid
// from done onward and hold until the next done.
interface ecc_dec_ctrl_if
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32
);
    logic                 start;
    logic [1:0]           cw_width;
    logic [AMBA_WORD-1:0] codeword_in;
    logic                 busy;
    logic                 done;
    logic [AMBA_WORD-1:0] data_out;
    logic [1:0]           num_of_errors;
    logic [AMBA_WORD-1:0] syn_cw;
    logic                 syn_small;
    logic                 syn_medium;
    logic [1:0]           syn_nof;
    logic [4:0]           syn_pos;
    state_t               dbg_state;

    // Requester plus syndrome-unit side (testbench / surrounding logic).
    modport master (
        output start, cw_width, codeword_in, syn_nof, syn_pos,
        input  busy, done, data_out, num_of_errors, syn_cw, syn_small, syn_medium, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  start, cw_width, codeword_in, syn_nof, syn_pos,
        output busy, done, data_out, num_of_errors, syn_cw, syn_small, syn_medium, dbg_state
    );
endinterface

// File: rtl/ecc_dec_ctrl_bit_fix.sv
// ecc_bit_fix: combinational single-bit corrector.
//   cw       in  : captured codeword (already masked to active width)
//   width    in  : width code
//   nof      in  : raw number-of-errors code from the syndrome unit
//   pos      in  : 1-based error position, 0 = overall parity bit (MSB of active width)
//   cw_fixed out : corrected codeword
//   oor      out : single error reported at a position outside the active width
//   nof_out  out : final error code (11 folded to 10, out-of-range single promoted to 10)
module ecc_bit_fix
    import ecc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] cw,
    input  logic [1:0]   width,
    input  logic [1:0]   nof,
    input  logic [4:0]   pos,
    output logic [W-1:0] cw_fixed,
    output logic         oor,
    output logic [1:0]   nof_out
);
    logic [1:0] nof_n;
    logic [5:0] nbits;
    logic [5:0] idx;

    always_comb begin
        nof_n    = (nof == 2'b11) ? NOF_DOUBLE : nof;
        nbits    = act_bits(width);
        // Position 0 names the overall parity bit, stored in the top active bit.
        idx      = (pos == 5'd0) ? (nbits - 6'd1) : ({1'b0, pos} - 6'd1);
        oor      = (nof_n == NOF_SINGLE) && (pos != 5'd0) && (idx >= nbits);
        cw_fixed = cw;
        if ((nof_n == NOF_SINGLE) && !oor)
            cw_fixed = cw ^ (W'(1) << idx);
        nof_out  = oor ? NOF_DOUBLE : nof_n;
    end
endmodule

// File: rtl/ecc_dec_ctrl.sv
// ecc_dec_ctrl: ECC decode sequencer. Captures a codeword on start, presents it to the
// syndrome unit, waits SYN_LAT cycles, flips one erroneous bit and reports the result.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : ecc_dec_ctrl_if.slave (request/response, syndrome unit, dbg_state)
//   Optional (macro ECC_ERR_CNT_EN defined):
//     cnt_clr    in  : synchronous clear of both counters, wins over an increment
//     corr_cnt   out : saturating count of corrected single errors
//     uncorr_cnt out : saturating count of uncorrectable results
// Latency start -> done is SYN_LAT + 2 cycles.
module ecc_dec_ctrl
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int SYN_LAT   = 1
) (
    input  logic           clk,
    input  logic           rst,
    ecc_dec_ctrl_if.slave  bus
`ifdef ECC_ERR_CNT_EN
    ,
    input  logic           cnt_clr,
    output logic [15:0]    corr_cnt,
    output logic [15:0]    uncorr_cnt
`endif
);
    state_t               state;
    logic [2:0]           lat_cnt;
    logic [1:0]           width_q;
    logic [AMBA_WORD-1:0] cw_q;
    logic [1:0]           nof_q;
    logic [4:0]           pos_q;
    logic                 syn_small_q;
    logic                 syn_medium_q;
    logic                 busy_q;
    logic                 done_q;
    logic [AMBA_WORD-1:0] data_q;
    logic [1:0]           noe_q;

    logic [AMBA_WORD-1:0] cw_fixed;
    logic                 fix_oor;
    logic [1:0]           nof_final;

    ecc_bit_fix #(.W(AMBA_WORD)) u_bit_fix (
        .cw       (cw_q),
        .width    (width_q),
        .nof      (nof_q),
        .pos      (pos_q),
        .cw_fixed (cw_fixed),
        .oor      (fix_oor),
        .nof_out  (nof_final)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= 3'd0;
            width_q      <= W_SMALL;
            cw_q         <= '0;
            nof_q        <= NOF_NONE;
            pos_q        <= 5'd0;
            syn_small_q  <= 1'b0;
            syn_medium_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_q       <= '0;
            noe_q        <= NOF_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cw_q         <= bus.codeword_in & AMBA_WORD'(width_mask(bus.cw_width));
                        width_q      <= bus.cw_width;
                        syn_small_q  <= (bus.cw_width == W_SMALL);
                        syn_medium_q <= (bus.cw_width == W_MEDIUM);
                        lat_cnt      <= 3'(SYN_LAT);
                        busy_q       <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // The syndrome result is valid on the edge where the count reaches 1.
                    if (lat_cnt == 3'd1) begin
                        nof_q <= bus.syn_nof;
                        pos_q <= bus.syn_pos;
                        state <= FIX;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                FIX: begin
                    data_q <= cw_fixed;
                    noe_q  <= nof_final;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ECC_ERR_CNT_EN
    // Counters advance on the edge that ends DONE, using the registered final result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= 16'd0;
            uncorr_cnt <= 16'd0;
        end else if (cnt_clr) begin
            corr_cnt   <= 16'd0;
            uncorr_cnt <= 16'd0;
        end else if (state == DONE) begin
            if (noe_q == NOF_SINGLE && corr_cnt != 16'hFFFF)
                corr_cnt <= corr_cnt + 16'd1;
            if (noe_q == NOF_DOUBLE && uncorr_cnt != 16'hFFFF)
                uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end
`endif

    assign bus.syn_cw        = cw_q;
    assign bus.syn_small     = syn_small_q;
    assign bus.syn_medium    = syn_medium_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.data_out      = data_q;
    assign bus.num_of_errors = noe_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_ecc_dec_ctrl.sv
// tb_ecc_dec_ctrl: directed bench for ecc_dec_ctrl with a stub syndrome unit whose
// syn_nof/syn_pos are held constant for each request.
module tb_ecc_dec_ctrl;
    import ecc_pkg::*;

    localparam int AW  = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecc_dec_ctrl_if #(.AMBA_WORD(AW)) bus ();

`ifdef ECC_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
`endif

    ecc_dec_ctrl #(.AMBA_WORD(AW), .SYN_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ECC_ERR_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
`endif
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Values seen in the first WAIT cycle of the latest decode.
    logic [31:0] w_cw;
    logic        w_small;
    logic        w_med;
    logic [31:0] w_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One request; returns cycles from the start cycle to the done cycle (start cycle = 0).
    task automatic decode(input logic [1:0] w, input logic [31:0] cw, input logic [1:0] nof,
                          input logic [4:0] pos, input bit clr_at_done, output int lat);
        bus.cw_width    = w;
        bus.codeword_in = cw;
        bus.syn_nof     = nof;
        bus.syn_pos     = pos;
        bus.start       = 1'b1;
        cyc();
        bus.start       = 1'b0;
        bus.codeword_in = $urandom;
        w_cw    = bus.syn_cw;
        w_small = bus.syn_small;
        w_med   = bus.syn_medium;
        w_dout  = bus.data_out;
        lat = 1;
        while (!bus.done && lat < 20) begin
            cyc();
            lat++;
        end
        chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
`ifdef ECC_ERR_CNT_EN
        if (clr_at_done) cnt_clr = 1'b1;
`endif
        cyc();
`ifdef ECC_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.cw_width    = W_LARGE;
        bus.codeword_in = '0;
        bus.syn_nof     = NOF_NONE;
        bus.syn_pos     = 5'd0;
`ifdef ECC_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst_busy",   {31'd0, bus.busy},       32'd0);
        chk("rst_done",   {31'd0, bus.done},       32'd0);
        chk("rst_small",  {31'd0, bus.syn_small},  32'd0);
        chk("rst_medium", {31'd0, bus.syn_medium}, 32'd0);
        chk("rst_syn_cw", bus.syn_cw,              32'd0);
        chk("rst_dout",   bus.data_out,            32'd0);
        chk("rst_noe",    {30'd0, bus.num_of_errors}, 32'd0);
        chk("rst_state",  {30'd0, bus.dbg_state},  {30'd0, IDLE});
        rst = 1'b0;
        cyc();

        // Large, no error.
        decode(W_LARGE, 32'h1234_5678, NOF_NONE, 5'd0, 1'b0, lat);
        chk("t1_latency", lat, LAT + 2);
        chk("t1_syn_cw",  w_cw, 32'h1234_5678);
        chk("t1_small",   {31'd0, w_small}, 32'd0);
        chk("t1_medium",  {31'd0, w_med}, 32'd0);
        chk("t1_dout",    bus.data_out, 32'h1234_5678);
        chk("t1_noe",     {30'd0, bus.num_of_errors}, 32'd0);

        // Small, single error at position 3: 0x5A ^ 0x04 = 0x5E.
        decode(W_SMALL, 32'hFFFF_FF5A, NOF_SINGLE, 5'd3, 1'b0, lat);
        chk("t2_syn_cw",  w_cw, 32'h0000_005A);
        chk("t2_small",   {31'd0, w_small}, 32'd1);
        chk("t2_medium",  {31'd0, w_med}, 32'd0);
        chk("t2_hold",    w_dout, 32'h1234_5678);
        chk("t2_dout",    bus.data_out, 32'h0000_005E);
        chk("t2_noe",     {30'd0, bus.num_of_errors}, 32'd1);

        // Medium, parity-bit error flips bit 15.
        decode(W_MEDIUM, 32'hABCD_8001, NOF_SINGLE, 5'd0, 1'b0, lat);
        chk("t3_syn_cw",  w_cw, 32'h0000_8001);
        chk("t3_medium",  {31'd0, w_med}, 32'd1);
        chk("t3_small",   {31'd0, w_small}, 32'd0);
        chk("t3_dout",    bus.data_out, 32'h0000_0001);
        chk("t3_noe",     {30'd0, bus.num_of_errors}, 32'd1);

        // Medium, position 20 lies outside 16 bits: no flip, uncorrectable.
        decode(W_MEDIUM, 32'h0000_8001, NOF_SINGLE, 5'd20, 1'b0, lat);
        chk("t4_dout",    bus.data_out, 32'h0000_8001);
        chk("t4_noe",     {30'd0, bus.num_of_errors}, 32'd2);

        // Width 11 acts as Large: parity error flips bit 31.
        decode(2'b11, 32'hDEAD_BEEF, NOF_SINGLE, 5'd0, 1'b0, lat);
        chk("t5_small",   {31'd0, w_small}, 32'd0);
        chk("t5_medium",  {31'd0, w_med}, 32'd0);
        chk("t5_dout",    bus.data_out, 32'h5EAD_BEEF);
        chk("t5_noe",     {30'd0, bus.num_of_errors}, 32'd1);

        // Large, highest position 31 flips bit 30.
        decode(W_LARGE, 32'h0000_0000, NOF_SINGLE, 5'd31, 1'b0, lat);
        chk("t6_dout",    bus.data_out, 32'h4000_0000);
        chk("t6_noe",     {30'd0, bus.num_of_errors}, 32'd1);

        // syn_nof = 11 treated as double.
        decode(W_LARGE, 32'h0000_00FF, 2'b11, 5'd5, 1'b0, lat);
        chk("t7_dout",    bus.data_out, 32'h0000_00FF);
        chk("t7_noe",     {30'd0, bus.num_of_errors}, 32'd2);

        // Large double error, plus a start pulse while busy that must be ignored.
        bus.cw_width    = W_LARGE;
        bus.codeword_in = 32'hA5A5_0F0F;
        bus.syn_nof     = NOF_DOUBLE;
        bus.syn_pos     = 5'd9;
        bus.start       = 1'b1;
        cyc();
        bus.codeword_in = 32'h1111_1111;
        cyc();
        bus.start       = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dones++;
            cyc();
        end
        chk("t8_one_done", dones, 1);
        chk("t8_idle",     {31'd0, bus.busy}, 32'd0);
        chk("t8_dout",     bus.data_out, 32'hA5A5_0F0F);
        chk("t8_noe",      {30'd0, bus.num_of_errors}, 32'd2);

        // Reset in WAIT drops the in-flight codeword.
        bus.cw_width    = W_LARGE;
        bus.codeword_in = 32'hCAFE_F00D;
        bus.syn_nof     = NOF_SINGLE;
        bus.syn_pos     = 5'd1;
        bus.start       = 1'b1;
        cyc();
        bus.start       = 1'b0;
        chk("t9_in_wait", {30'd0, bus.dbg_state}, {30'd0, WAIT});
        rst = 1'b1;
        #1;
        chk("t9_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("t9_rst_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        chk("t9_rst_syncw", bus.syn_cw, 32'd0);
        chk("t9_rst_dout",  bus.data_out, 32'd0);
        cyc();
        cyc();
        chk("t9_no_done",   {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        decode(W_SMALL, 32'h0000_00C3, NOF_NONE, 5'd0, 1'b0, lat);
        chk("t9_latency",  lat, LAT + 2);
        chk("t9_dout",     bus.data_out, 32'h0000_00C3);
        chk("t9_noe",      {30'd0, bus.num_of_errors}, 32'd0);

`ifdef ECC_ERR_CNT_EN
        chk("cnt_corr_zero",   {16'd0, corr_cnt}, 32'd0);
        chk("cnt_uncorr_zero", {16'd0, uncorr_cnt}, 32'd0);
        decode(W_LARGE, 32'h0000_0001, NOF_SINGLE, 5'd1, 1'b0, lat);
        decode(W_SMALL, 32'h0000_0010, NOF_SINGLE, 5'd2, 1'b0, lat);
        decode(W_LARGE, 32'h0000_0000, NOF_DOUBLE, 5'd4, 1'b0, lat);
        decode(W_MEDIUM, 32'h0000_0100, NOF_SINGLE, 5'd0, 1'b0, lat);
        decode(W_SMALL, 32'h0000_0003, NOF_SINGLE, 5'd12, 1'b0, lat);
        chk("cnt_corr_3",   {16'd0, corr_cnt}, 32'd3);
        chk("cnt_uncorr_2", {16'd0, uncorr_cnt}, 32'd2);
        decode(W_LARGE, 32'h0000_0002, NOF_SINGLE, 5'd2, 1'b1, lat);
        chk("cnt_corr_clr",   {16'd0, corr_cnt}, 32'd0);
        chk("cnt_uncorr_clr", {16'd0, uncorr_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
